// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA raster timing generator (sync, blank, position)
module vga_sync_gen #(
    parameter int   C_H_ACTIVE    = 640,
    parameter int   C_H_FRONT     = 16,
    parameter int   C_H_SYNC      = 96,
    parameter int   C_H_BACK      = 48,
    parameter int   C_V_ACTIVE    = 480,
    parameter int   C_V_FRONT     = 10,
    parameter int   C_V_SYNC      = 2,
    parameter int   C_V_BACK      = 33,
    parameter logic C_HSYNC_POL   = 1'b0,
    parameter logic C_VSYNC_POL   = 1'b0,
    parameter int   C_COUNT_WIDTH = 10
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    output logic                     o_HSync,
    output logic                     o_VSync,
    output logic                     o_HBlank,
    output logic                     o_VBlank,
    output logic                     o_Active,
    output logic [C_COUNT_WIDTH-1:0] o_Col_Count,
    output logic [C_COUNT_WIDTH-1:0] o_Row_Count,
    output logic                     o_Frame_Start
);
    localparam int W       = C_COUNT_WIDTH;
    localparam int H_TOTAL = C_H_ACTIVE + C_H_FRONT + C_H_SYNC + C_H_BACK;
    localparam int V_TOTAL = C_V_ACTIVE + C_V_FRONT + C_V_SYNC + C_V_BACK;
    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] H_LAST  = W'(H_TOTAL - 1);
    localparam logic [W-1:0] V_LAST  = W'(V_TOTAL - 1);
    localparam logic [W-1:0] H_ACT   = W'(C_H_ACTIVE);
    localparam logic [W-1:0] V_ACT   = W'(C_V_ACTIVE);
    localparam logic [W-1:0] HS_FIRST = W'(C_H_ACTIVE + C_H_FRONT);
    localparam logic [W-1:0] HS_LAST  = W'(C_H_ACTIVE + C_H_FRONT + C_H_SYNC - 1);
    localparam logic [W-1:0] VS_FIRST = W'(C_V_ACTIVE + C_V_FRONT);
    localparam logic [W-1:0] VS_LAST  = W'(C_V_ACTIVE + C_V_FRONT + C_V_SYNC - 1);

    logic [W-1:0] col_q, col_d, row_q, row_d;
    logic         hsync_q, hsync_d, vsync_q, vsync_d;
    logic         hblank_q, hblank_d, vblank_q, vblank_d;
    logic         active_q, active_d, fstart_q, fstart_d;
    logic         col_wrap, row_wrap;

    // Next position, and flags decoded from that next position so that
    // registered flags always describe the registered position beside them.
    always_comb begin
        col_wrap = col_q == H_LAST;
        row_wrap = row_q == V_LAST;
        col_d    = col_wrap ? '0 : col_q + ONE;
        row_d    = !col_wrap ? row_q : (row_wrap ? '0 : row_q + ONE);
        hsync_d  = (col_d >= HS_FIRST && col_d <= HS_LAST) ? C_HSYNC_POL : ~C_HSYNC_POL;
        vsync_d  = (row_d >= VS_FIRST && row_d <= VS_LAST) ? C_VSYNC_POL : ~C_VSYNC_POL;
        hblank_d = col_d >= H_ACT;
        vblank_d = row_d >= V_ACT;
        active_d = ~hblank_d & ~vblank_d;
        fstart_d = col_d == '0 && row_d == '0;
    end

    // Raster state; reset parks the generator at the top-left pixel.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            col_q    <= '0;
            row_q    <= '0;
            hsync_q  <= ~C_HSYNC_POL;
            vsync_q  <= ~C_VSYNC_POL;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            active_q <= 1'b1;
            fstart_q <= 1'b1;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
            active_q <= active_d;
            fstart_q <= fstart_d;
        end
    end

    assign o_HSync       = hsync_q;
    assign o_VSync       = vsync_q;
    assign o_HBlank      = hblank_q;
    assign o_VBlank      = vblank_q;
    assign o_Active      = active_q;
    assign o_Col_Count   = col_q;
    assign o_Row_Count   = row_q;
    assign o_Frame_Start = fstart_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for default and reduced-size raster generators
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic rst_d = 1'b1, rst_s = 1'b1;
    always #5 clk = ~clk;

    logic hs_d, vs_d, hb_d, vb_d, ac_d, fs_d;
    logic [9:0] col_d, row_d;
    logic hs_s, vs_s, hb_s, vb_s, ac_s, fs_s;
    logic [9:0] col_s, row_s;
    logic [25:0] obs_d, obs_s;
    assign obs_d = {hs_d, vs_d, hb_d, vb_d, ac_d, fs_d, col_d, row_d};
    assign obs_s = {hs_s, vs_s, hb_s, vb_s, ac_s, fs_s, col_s, row_s};

    vga_sync_gen u_def (
        .i_Clk(clk), .i_Rst(rst_d), .o_HSync(hs_d), .o_VSync(vs_d),
        .o_HBlank(hb_d), .o_VBlank(vb_d), .o_Active(ac_d),
        .o_Col_Count(col_d), .o_Row_Count(row_d), .o_Frame_Start(fs_d)
    );

    vga_sync_gen #(
        .C_H_ACTIVE(8), .C_H_FRONT(2), .C_H_SYNC(3), .C_H_BACK(3),
        .C_V_ACTIVE(4), .C_V_FRONT(1), .C_V_SYNC(2), .C_V_BACK(1),
        .C_HSYNC_POL(1'b1), .C_VSYNC_POL(1'b0)
    ) u_small (
        .i_Clk(clk), .i_Rst(rst_s), .o_HSync(hs_s), .o_VSync(vs_s),
        .o_HBlank(hb_s), .o_VBlank(vb_s), .o_Active(ac_s),
        .o_Col_Count(col_s), .o_Row_Count(row_s), .o_Frame_Start(fs_s)
    );

    int total = 0, bad = 0;
    int mcd = 0, mrd = 0, mcs = 0, mrs = 0;
    logic [25:0] q_d[$], q_s[$];

    function automatic logic [25:0] exp_vec(int c, int r, int ha, int hf, int hsw,
                                            int va, int vf, int vsw, logic hp, logic vp);
        logic h, v, hb, vb;
        h  = (c >= ha + hf && c < ha + hf + hsw) ? hp : ~hp;
        v  = (r >= va + vf && r < va + vf + vsw) ? vp : ~vp;
        hb = c >= ha;
        vb = r >= va;
        return {h, v, hb, vb, !hb && !vb, c == 0 && r == 0, 10'(c), 10'(r)};
    endfunction

    task automatic cyc_d(input logic r);
        rst_d = r;
        @(posedge clk);
        if (r) begin
            mcd = 0; mrd = 0;
        end else begin
            mcd++;
            if (mcd == 800) begin mcd = 0; mrd = (mrd == 524) ? 0 : mrd + 1; end
        end
        q_d.push_back(exp_vec(mcd, mrd, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0));
        #1;
    endtask

    task automatic cyc_s(input logic r);
        rst_s = r;
        @(posedge clk);
        if (r) begin
            mcs = 0; mrs = 0;
        end else begin
            mcs++;
            if (mcs == 16) begin mcs = 0; mrs = (mrs == 7) ? 0 : mrs + 1; end
        end
        q_s.push_back(exp_vec(mcs, mrs, 8, 2, 3, 4, 1, 2, 1'b1, 1'b0));
        #1;
    endtask

    task automatic test_reset;
        logic [25:0] e;
        for (int i = 0; i < 3; i++) begin
            cyc_d(1'b1);
            e = q_d.pop_front();
            total++;
            if (obs_d !== e) begin bad++; $display("FAIL reset_hold%0d got=%h exp=%h", i, obs_d, e); end
        end
        cyc_d(1'b0);
        e = q_d.pop_front();
        total++;
        if (obs_d !== e) begin bad++; $display("FAIL reset_release got=%h exp=%h", obs_d, e); end
        total++;
        if (col_d !== 10'd1) begin bad++; $display("FAIL reset_first_col got=%0d exp=1", col_d); end
    endtask

    task automatic test_line_sweep;
        logic [25:0] e;
        int hs_low = 0, hb_rise = -1, last0 = -1, period = -1;
        logic prev_hb = 1'b0;
        for (int i = 0; i < 2400; i++) begin
            cyc_d(1'b0);
            e = q_d.pop_front();
            total++;
            if (obs_d !== e) begin bad++; $display("FAIL line_vec got=%h exp=%h", obs_d, e); end
            if (row_d == 10'd0 && hs_d == 1'b0) hs_low++;
            if (row_d == 10'd0 && hb_d && !prev_hb && hb_rise < 0) hb_rise = int'(col_d);
            prev_hb = hb_d;
            if (col_d == 10'd0) begin
                if (last0 >= 0 && period < 0) period = i - last0;
                last0 = i;
            end
        end
        total++;
        if (hs_low != 96) begin bad++; $display("FAIL hsync_width got=%0d exp=96", hs_low); end
        total++;
        if (hb_rise != 640) begin bad++; $display("FAIL hblank_rise got=%0d exp=640", hb_rise); end
        total++;
        if (period != 800) begin bad++; $display("FAIL line_period got=%0d exp=800", period); end
    endtask

    task automatic test_col_wrap;
        logic [25:0] e;
        logic [9:0] r0;
        bit found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            cyc_d(1'b0);
            e = q_d.pop_front();
            if (col_d == 10'd799) found = 1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL wrap_timeout got=none exp=col799"); end
        r0 = row_d;
        cyc_d(1'b0);
        e = q_d.pop_front();
        total++;
        if (col_d !== 10'd0 || row_d !== r0 + 10'd1) begin
            bad++; $display("FAIL col_wrap got=%0d/%0d exp=0/%0d", col_d, row_d, r0 + 10'd1);
        end
        total++;
        if (obs_d !== e) begin bad++; $display("FAIL wrap_vec got=%h exp=%h", obs_d, e); end
    endtask

    task automatic test_vertical;
        logic [25:0] e;
        int vs_low = 0, bad_edge = 0, fs_prev = -1, fs_per = -1;
        logic prev_vs;
        cyc_s(1'b1);
        e = q_s.pop_front();
        total++;
        if (obs_s !== e) begin bad++; $display("FAIL small_reset got=%h exp=%h", obs_s, e); end
        prev_vs = vs_s;
        fs_prev = 0;
        for (int i = 1; i <= 256; i++) begin
            cyc_s(1'b0);
            e = q_s.pop_front();
            total++;
            if (obs_s !== e) begin bad++; $display("FAIL vert_vec got=%h exp=%h", obs_s, e); end
            if (!vs_s) vs_low++;
            if (vs_s != prev_vs && col_s != 10'd0) bad_edge++;
            prev_vs = vs_s;
            if (fs_s) begin
                if (fs_per < 0) fs_per = i - fs_prev;
                fs_prev = i;
            end
        end
        total++;
        if (vs_low != 64) begin bad++; $display("FAIL vsync_width got=%0d exp=64", vs_low); end
        total++;
        if (bad_edge != 0) begin bad++; $display("FAIL vsync_edge got=%0d exp=0", bad_edge); end
        total++;
        if (fs_per != 128) begin bad++; $display("FAIL frame_period got=%0d exp=128", fs_per); end
    endtask

    task automatic test_reset_mid;
        logic [25:0] e;
        bit found = 0;
        int per = -1;
        for (int i = 0; i < 300 && !found; i++) begin
            cyc_s(1'b0);
            e = q_s.pop_front();
            if (row_s == 10'd5 && col_s == 10'd7) found = 1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL mid_timeout got=none exp=r5c7"); end
        for (int i = 0; i < 3; i++) begin
            cyc_s(1'b1);
            e = q_s.pop_front();
            total++;
            if (obs_s !== e) begin bad++; $display("FAIL mid_reset%0d got=%h exp=%h", i, obs_s, e); end
        end
        for (int i = 1; i <= 300 && per < 0; i++) begin
            cyc_s(1'b0);
            e = q_s.pop_front();
            total++;
            if (obs_s !== e) begin bad++; $display("FAIL mid_vec got=%h exp=%h", obs_s, e); end
            if (fs_s) per = i;
        end
        total++;
        if (per != 128) begin bad++; $display("FAIL mid_frame_period got=%0d exp=128", per); end
    endtask

    task automatic test_override_hsync;
        logic [25:0] e;
        logic [15:0] mask = '0;
        int last0 = -1, period = -1;
        for (int i = 0; i < 48; i++) begin
            cyc_s(1'b0);
            e = q_s.pop_front();
            total++;
            if (obs_s !== e) begin bad++; $display("FAIL ovr_vec got=%h exp=%h", obs_s, e); end
            if (hs_s) mask[col_s[3:0]] = 1'b1;
            if (col_s == 10'd0) begin
                if (last0 >= 0 && period < 0) period = i - last0;
                last0 = i;
            end
        end
        total++;
        if (mask !== 16'h1C00) begin bad++; $display("FAIL ovr_hsync_cols got=%h exp=1c00", mask); end
        total++;
        if (period != 16) begin bad++; $display("FAIL ovr_line_period got=%0d exp=16", period); end
    endtask

    initial begin
        test_reset;
        test_line_sweep;
        test_col_wrap;
        test_vertical;
        test_reset_mid;
        test_override_hsync;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
